// File: rtl/hazard_pkg.sv
// Shared types and constant control words for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } hz_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic ifid_flush;
        logic hzrd;
        logic memwb_bubble;
    } hz_ctrl_t;

    localparam hz_ctrl_t HZ_NOMINAL = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam hz_ctrl_t HZ_FREEZE  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    localparam hz_ctrl_t HZ_FLUSH   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    localparam hz_ctrl_t HZ_LOADUSE = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    localparam hz_ctrl_t HZ_RESET   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    // Priority among non-memory hazards: a taken branch discards the ID
    // instruction, so any load-use match against it is moot.
    function automatic hz_ctrl_t run_rules(input logic branch, input logic loaduse);
        if (branch)
            return HZ_FLUSH;
        else if (loaduse)
            return HZ_LOADUSE;
        return HZ_NOMINAL;
    endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the stall and flush event counters.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + W'(1);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes, data-memory
// wait freezes with a watchdog, and saturating stall/flush counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [4:0]       ID_rs1,
    input  logic [4:0]       ID_rs2,
    input  logic             ID_UsesRs2,
    input  logic [4:0]       EX_rd,
    input  logic             EX_MemRead,
    input  logic             EX_BranchTaken,
    input  logic             MEM_Access,
    input  logic             DMEM_ready,
    output logic             PC_en,
    output logic             IFID_en,
    output logic             IDEX_en,
    output logic             EXMEM_en,
    output logic             IFID_flush,
    output logic             HZRDcontrol,
    output logic             MEMWB_bubble,
    output logic             MEM_err,
    output logic [CNT_W-1:0] STALL_CNT,
    output logic [CNT_W-1:0] FLUSH_CNT
);

    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

    hz_state_t   state, next_state;
    logic [WAIT_W-1:0] wait_cnt, next_wait;
    hz_ctrl_t    ctrl;
    logic        memstall, loaduse;
    logic        stall_inc, flush_inc;

    assign memstall = MEM_Access && !DMEM_ready;
    assign loaduse  = EX_MemRead && (EX_rd != REG_ZERO) &&
                      ((EX_rd == ID_rs1) || (ID_UsesRs2 && (EX_rd == ID_rs2)));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= RUN;
            wait_cnt <= '0;
            MEM_err  <= 1'b0;
        end else begin
            state    <= next_state;
            wait_cnt <= next_wait;
            if (next_state == ERROR)
                MEM_err <= 1'b1;
        end
    end

    always_comb begin
        ctrl       = HZ_NOMINAL;
        next_state = state;
        next_wait  = wait_cnt;
        stall_inc  = 1'b0;
        flush_inc  = 1'b0;
        unique case (state)
            RUN: begin
                if (memstall) begin
                    ctrl       = HZ_FREEZE;
                    stall_inc  = 1'b1;
                    next_state = MEM_WAIT;
                    next_wait  = WAIT_W'(1);
                end else begin
                    ctrl      = run_rules(EX_BranchTaken, loaduse);
                    flush_inc = EX_BranchTaken;
                    stall_inc = !EX_BranchTaken && loaduse;
                end
            end
            MEM_WAIT: begin
                if (!DMEM_ready) begin
                    ctrl      = HZ_FREEZE;
                    stall_inc = 1'b1;
                    if (wait_cnt >= WAIT_W'(MEM_TIMEOUT))
                        next_state = ERROR;
                    else
                        next_wait = wait_cnt + WAIT_W'(1);
                end else begin
                    // Completion cycle: the held EX instruction is re-evaluated.
                    ctrl       = run_rules(EX_BranchTaken, loaduse);
                    flush_inc  = EX_BranchTaken;
                    stall_inc  = !EX_BranchTaken && loaduse;
                    next_state = RUN;
                    next_wait  = '0;
                end
            end
            ERROR: begin
                ctrl = HZ_FREEZE;
            end
            default: begin
                ctrl       = HZ_FREEZE;
                next_state = RUN;
                next_wait  = '0;
            end
        endcase
        if (RST)
            ctrl = HZ_RESET;
    end

    assign PC_en        = ctrl.pc_en;
    assign IFID_en      = ctrl.ifid_en;
    assign IDEX_en      = ctrl.idex_en;
    assign EXMEM_en     = ctrl.exmem_en;
    assign IFID_flush   = ctrl.ifid_flush;
    assign HZRDcontrol  = ctrl.hzrd;
    assign MEMWB_bubble = ctrl.memwb_bubble;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (stall_inc),
        .count (STALL_CNT)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (flush_inc),
        .count (FLUSH_CNT)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (MEM_TIMEOUT=4, CNT_W=3).
module tb_hazard_ctrl;

    logic       CLK;
    logic       RST;
    logic [4:0] ID_rs1, ID_rs2, EX_rd;
    logic       ID_UsesRs2, EX_MemRead, EX_BranchTaken, MEM_Access, DMEM_ready;
    logic       PC_en, IFID_en, IDEX_en, EXMEM_en, IFID_flush, HZRDcontrol, MEMWB_bubble;
    logic       MEM_err;
    logic [2:0] STALL_CNT, FLUSH_CNT;
    logic [6:0] ctl;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // {PC_en, IFID_en, IDEX_en, EXMEM_en, IFID_flush, HZRDcontrol, MEMWB_bubble}
    localparam logic [6:0] C_NOM    = 7'b1111000;
    localparam logic [6:0] C_FREEZE = 7'b0000001;
    localparam logic [6:0] C_FLUSH  = 7'b1111110;
    localparam logic [6:0] C_LU     = 7'b0011010;
    localparam logic [6:0] C_RST    = 7'b0000111;

    assign ctl = {PC_en, IFID_en, IDEX_en, EXMEM_en, IFID_flush, HZRDcontrol, MEMWB_bubble};

    hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(3)) dut (
        .CLK            (CLK),
        .RST            (RST),
        .ID_rs1         (ID_rs1),
        .ID_rs2         (ID_rs2),
        .ID_UsesRs2     (ID_UsesRs2),
        .EX_rd          (EX_rd),
        .EX_MemRead     (EX_MemRead),
        .EX_BranchTaken (EX_BranchTaken),
        .MEM_Access     (MEM_Access),
        .DMEM_ready     (DMEM_ready),
        .PC_en          (PC_en),
        .IFID_en        (IFID_en),
        .IDEX_en        (IDEX_en),
        .EXMEM_en       (EXMEM_en),
        .IFID_flush     (IFID_flush),
        .HZRDcontrol    (HZRDcontrol),
        .MEMWB_bubble   (MEMWB_bubble),
        .MEM_err        (MEM_err),
        .STALL_CNT      (STALL_CNT),
        .FLUSH_CNT      (FLUSH_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got running required finished");
        $fatal(1);
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        ID_rs1 = 5'd0; ID_rs2 = 5'd0; ID_UsesRs2 = 1'b0; EX_rd = 5'd0;
        EX_MemRead = 1'b0; EX_BranchTaken = 1'b0; MEM_Access = 1'b0; DMEM_ready = 1'b1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        idle();
        step();
        step();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        RST = 1'b1;
        #1;
        n_cmp++;
        if (ctl !== C_RST) begin n_bad++; $display("FAIL reset_ctl got %b required %b", ctl, C_RST); end
        step();
        n_cmp++;
        if (STALL_CNT !== 3'd0 || FLUSH_CNT !== 3'd0 || MEM_err !== 1'b0) begin
            n_bad++; $display("FAIL reset_regs got %0d/%0d/%b required 0/0/0", STALL_CNT, FLUSH_CNT, MEM_err);
        end
        RST = 1'b0;
        #3;
        n_cmp++;
        if (ctl !== C_NOM) begin n_bad++; $display("FAIL post_reset_ctl got %b required %b", ctl, C_NOM); end
    endtask

    task automatic test_loaduse();
        do_reset();
        // ld x5 in EX, add x6,x5,x7 in ID
        EX_MemRead = 1'b1; EX_rd = 5'd5; ID_rs1 = 5'd5; ID_rs2 = 5'd7; ID_UsesRs2 = 1'b1;
        #3;
        n_cmp++;
        if (ctl !== C_LU) begin n_bad++; $display("FAIL loaduse_rs1_ctl got %b required %b", ctl, C_LU); end
        step();
        n_cmp++;
        if (STALL_CNT !== 3'd1) begin n_bad++; $display("FAIL loaduse_rs1_cnt got %0d required 1", STALL_CNT); end
        // rs2 match with rs2 used
        ID_rs1 = 5'd6; ID_rs2 = 5'd5; ID_UsesRs2 = 1'b1;
        #3;
        n_cmp++;
        if (ctl !== C_LU) begin n_bad++; $display("FAIL loaduse_rs2_ctl got %b required %b", ctl, C_LU); end
        step();
        // rs2 match but rs2 not used
        ID_UsesRs2 = 1'b0;
        #3;
        n_cmp++;
        if (ctl !== C_NOM) begin n_bad++; $display("FAIL loaduse_nors2_ctl got %b required %b", ctl, C_NOM); end
        step();
        // EX_rd = x0 never stalls
        EX_rd = 5'd0; ID_rs1 = 5'd0; ID_rs2 = 5'd0; ID_UsesRs2 = 1'b1;
        #3;
        n_cmp++;
        if (ctl !== C_NOM) begin n_bad++; $display("FAIL loaduse_x0_ctl got %b required %b", ctl, C_NOM); end
        step();
        n_cmp++;
        if (STALL_CNT !== 3'd2) begin n_bad++; $display("FAIL loaduse_total_cnt got %0d required 2", STALL_CNT); end
        idle();
    endtask

    task automatic test_branch_priority();
        do_reset();
        EX_MemRead = 1'b1; EX_rd = 5'd5; ID_rs1 = 5'd5; ID_UsesRs2 = 1'b0; EX_BranchTaken = 1'b1;
        #3;
        n_cmp++;
        if (ctl !== C_FLUSH) begin n_bad++; $display("FAIL branch_ctl got %b required %b", ctl, C_FLUSH); end
        step();
        n_cmp++;
        if (FLUSH_CNT !== 3'd1 || STALL_CNT !== 3'd0) begin
            n_bad++; $display("FAIL branch_cnt got flush=%0d stall=%0d required flush=1 stall=0", FLUSH_CNT, STALL_CNT);
        end
        idle();
    endtask

    task automatic test_mem_wait();
        do_reset();
        MEM_Access = 1'b1; DMEM_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            // load-use and branch seen mid-freeze must be ignored
            if (i == 1) begin
                EX_MemRead = 1'b1; EX_rd = 5'd3; ID_rs1 = 5'd3; EX_BranchTaken = 1'b1;
            end else begin
                EX_MemRead = 1'b0; EX_rd = 5'd0; ID_rs1 = 5'd0; EX_BranchTaken = 1'b0;
            end
            #3;
            n_cmp++;
            if (ctl !== C_FREEZE) begin n_bad++; $display("FAIL memwait_freeze%0d got %b required %b", i, ctl, C_FREEZE); end
            step();
        end
        EX_MemRead = 1'b0; EX_rd = 5'd0; ID_rs1 = 5'd0; EX_BranchTaken = 1'b0;
        DMEM_ready = 1'b1;
        #3;
        n_cmp++;
        if (ctl !== C_NOM) begin n_bad++; $display("FAIL memwait_done_ctl got %b required %b", ctl, C_NOM); end
        step();
        n_cmp++;
        if (STALL_CNT !== 3'd3 || FLUSH_CNT !== 3'd0) begin
            n_bad++; $display("FAIL memwait_cnt got stall=%0d flush=%0d required stall=3 flush=0", STALL_CNT, FLUSH_CNT);
        end
        // Back in RUN: a not-ready memory with no access does not freeze
        MEM_Access = 1'b0; DMEM_ready = 1'b0;
        #3;
        n_cmp++;
        if (ctl !== C_NOM) begin n_bad++; $display("FAIL memwait_back_run got %b required %b", ctl, C_NOM); end
        idle();
    endtask

    task automatic test_timeout();
        do_reset();
        MEM_Access = 1'b1; DMEM_ready = 1'b0;
        for (int i = 0; i < 4; i++) step();
        n_cmp++;
        if (MEM_err !== 1'b0) begin n_bad++; $display("FAIL timeout_early got %b required 0", MEM_err); end
        step();
        n_cmp++;
        if (MEM_err !== 1'b1) begin n_bad++; $display("FAIL timeout_err got %b required 1", MEM_err); end
        MEM_Access = 1'b0; DMEM_ready = 1'b1;
        #3;
        n_cmp++;
        if (ctl !== C_FREEZE) begin n_bad++; $display("FAIL error_freeze got %b required %b", ctl, C_FREEZE); end
        step();
        n_cmp++;
        if (MEM_err !== 1'b1 || STALL_CNT !== 3'd5) begin
            n_bad++; $display("FAIL error_sticky got err=%b stall=%0d required err=1 stall=5", MEM_err, STALL_CNT);
        end
        #2;
        RST = 1'b1;
        #1;
        n_cmp++;
        if (ctl !== C_RST || MEM_err !== 1'b0 || STALL_CNT !== 3'd0) begin
            n_bad++; $display("FAIL error_reset got ctl=%b err=%b stall=%0d required ctl=%b err=0 stall=0", ctl, MEM_err, STALL_CNT, C_RST);
        end
        step();
        RST = 1'b0;
        #3;
        n_cmp++;
        if (ctl !== C_NOM) begin n_bad++; $display("FAIL error_reset_run got %b required %b", ctl, C_NOM); end
        idle();
    endtask

    task automatic test_saturation();
        logic [2:0] exp;
        do_reset();
        EX_BranchTaken = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            exp = (i > 7) ? 3'd7 : 3'(i);
            n_cmp++;
            if (FLUSH_CNT !== exp) begin n_bad++; $display("FAIL flush_sat%0d got %0d required %0d", i, FLUSH_CNT, exp); end
        end
        idle();
    endtask

    task automatic test_async_reset_mid_wait();
        do_reset();
        MEM_Access = 1'b1; DMEM_ready = 1'b0;
        step();
        step();
        #3;
        RST = 1'b1;
        #1;
        n_cmp++;
        if (ctl !== C_RST || STALL_CNT !== 3'd0) begin
            n_bad++; $display("FAIL async_reset got ctl=%b stall=%0d required ctl=%b stall=0", ctl, STALL_CNT, C_RST);
        end
        #3;
        RST = 1'b0;
        // Still not ready but no access: MEM_WAIT would freeze, RUN must not
        MEM_Access = 1'b0; DMEM_ready = 1'b0;
        #1;
        n_cmp++;
        if (ctl !== C_NOM) begin n_bad++; $display("FAIL async_reset_state got %b required %b", ctl, C_NOM); end
        step();
        n_cmp++;
        if (STALL_CNT !== 3'd0) begin n_bad++; $display("FAIL async_reset_cnt got %0d required 0", STALL_CNT); end
        idle();
    endtask

    initial begin
        RST = 1'b0;
        idle();
        #2;
        test_reset();
        test_loaduse();
        test_branch_priority();
        test_mem_wait();
        test_timeout();
        test_saturation();
        test_async_reset_mid_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
